// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings, port indices and in-flight access record
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic port;
    logic we;
    logic oor;
  } access_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - combinational 2-way round-robin pick
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = PORT0;
    if (req[0] && req[1]) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_WIDTH = 12,
  parameter int unsigned DEPTH         = 18
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     err0,
  output logic                     err1,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  logic [1:0]               state;
  logic                     last;
  access_t                  cur;
  logic                     pick;
  logic                     pick_valid;
  logic                     sel_we;
  logic                     sel_oor;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  rr_pick2 u_pick (
    .req    ({req1, req0}),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign sel_we    = (pick == PORT1) ? we1 : we0;
  assign sel_addr  = (pick == PORT1) ? addr1 : addr0;
  assign sel_wdata = (pick == PORT1) ? wdata1 : wdata0;
  assign sel_oor   = !(32'(sel_addr) < DEPTH);

  // Outputs are registered: what is assigned on leaving a state is visible in the next one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last       <= PORT1;
      cur        <= '0;
      mem_wEn    <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_wEn <= 1'b0;
          if (pick_valid) begin
            mem_addr   <= sel_addr;
            mem_dataIn <= sel_wdata;
            mem_wEn    <= sel_we & ~sel_oor;
            cur        <= '{port: pick, we: sel_we, oor: sel_oor};
            last       <= pick;
            if (pick == PORT1) gnt1 <= 1'b1;
            else               gnt0 <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Memory sampled the address on the falling edge of ISSUE, so mem_dataOut is settled here.
          mem_wEn <= 1'b0;
          if (cur.port == PORT1) begin
            if (!cur.we) begin
              rvalid1 <= 1'b1;
              rdata1  <= cur.oor ? '0 : mem_dataOut;
            end
            err1 <= cur.oor;
          end else begin
            if (!cur.we) begin
              rvalid0 <= 1'b1;
              rdata0  <= cur.oor ? '0 : mem_dataOut;
            end
            err0 <= cur.oor;
          end
          state <= ST_CAPTURE;
        end
        default: begin
          mem_wEn <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning memory word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, meaning memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 18, meaning number of valid words; addresses >= DEPTH are out of range.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, a synchronous, active-low reset sampled on the rising edge of clk.
REQ-006 The block SHALL have ports req0 and req1, input, 1 each, requester x asks for one memory access.
REQ-007 The block SHALL have ports we0 and we1, input, 1 each, 1 for write and 0 for read.
REQ-008 The block SHALL have ports addr0 and addr1, input, ADDRESS_WIDTH each, the access address.
REQ-009 The block SHALL have ports wdata0 and wdata1, input, DATA_WIDTH each, the write data.
REQ-010 The block SHALL have ports gnt0 and gnt1, output, 1 each, a one-cycle pulse meaning the request was accepted.
REQ-011 The block SHALL have ports rvalid0 and rvalid1, output, 1 each, a one-cycle pulse meaning rdata is valid.
REQ-012 The block SHALL have ports rdata0 and rdata1, output, DATA_WIDTH each, the read result.
REQ-013 The block SHALL have ports err0 and err1, output, 1 each, a one-cycle pulse coincident with rvalid or write completion for an out-of-range address.
REQ-014 The block SHALL have memory-side ports mem_wEn (output, 1), mem_addr (output, ADDRESS_WIDTH), mem_dataIn (output, DATA_WIDTH) and mem_dataOut (input, DATA_WIDTH); the memory samples these on the falling edge of clk.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and CAPTURE; every output is registered.
REQ-016 IDLE with any reqx=1: the FSM SHALL select a winner, register its we/addr/wdata onto mem_*, and move to ISSUE.
REQ-017 IDLE with no request: the FSM SHALL stay in IDLE, with mem_wEn=0 and all pulses at 0.
REQ-018 ISSUE: gnt of the winner SHALL be 1 for exactly this cycle, and mem_wEn=1 only for an in-range write; the next state is CAPTURE.
REQ-019 CAPTURE: mem_wEn SHALL be 0.
REQ-020 CAPTURE for an in-range read: the block SHALL latch mem_dataOut into the winner's rdata.
REQ-021 CAPTURE for any read: rvalid of the winner SHALL be 1 for one cycle; the next state is IDLE.
REQ-022 Timing: a request seen in IDLE at cycle C SHALL give gnt in C+1 and rvalid in C+2, and the next arbitration SHALL occur in C+3 at the earliest.
REQ-023 Requester rule: reqx, wex, addrx and wdatax SHALL be held stable until gntx is seen; reqx sampled after gntx starts a new request.
REQ-024 Arbitration SHALL be 2-way round-robin: on contention the port not granted last wins; without contention the sole requester wins; last-grant updates only on a grant.
REQ-025 An out-of-range address (addr >= DEPTH) SHALL still be granted, with mem_wEn forced to 0.
REQ-026 An out-of-range read SHALL return rdata=0 with rvalid=1 and err=1; an out-of-range write SHALL pulse err in CAPTURE.
REQ-027 rdata of a port SHALL hold its value until that port's next read completes; writes SHALL NOT alter rdata or pulse rvalid.
REQ-028 A request that drops before grant SHALL simply be ignored.

Reset
REQ-029 When reset_n=0 at a rising edge: state=IDLE, last-grant=port1 (so port0 wins the first contention), mem_wEn=0, mem_addr=0, mem_dataIn=0, gnt*/rvalid*/err*=0, rdata*=0.
REQ-030 Reset during ISSUE SHALL leave any write issued in that ISSUE cycle done; reset during ISSUE or CAPTURE SHALL produce no rvalid or err for the aborted access.

Structure
REQ-031 The state encodings (IDLE/ISSUE/CAPTURE) and the port index constants SHALL be defined in the shared package mem_arbiter_pkg.
REQ-032 The round-robin selection SHALL be a sub-module rr_pick2 (inputs req[1:0], last; outputs winner, valid), purely combinational.

Verification
REQ-033 Scenario: after reset, req0 reads addr 5 (memory word 5 = 0xDEADBEEF) -> gnt0 in C+1, rvalid0=1 with rdata0=0xDEADBEEF in C+2, err0=0.
REQ-034 Scenario: req1 writes 0x12345678 to addr 3, then req0 reads addr 3 -> mem_wEn high only in the write's ISSUE cycle, and rdata0=0x12345678.
REQ-035 Scenario: req0 and req1 held high together with reads for 8 accesses -> grant order 0,1,0,1,0,1,0,1, and one grant every 3 cycles.
REQ-036 Scenario: req0 reads addr 18 with DEPTH=18 -> gnt0, then rvalid0=1, err0=1, rdata0=0, mem_wEn never 1; an out-of-range write -> memory unchanged, err0 pulse.
REQ-037 Scenario: reset_n=0 in the ISSUE cycle of a read -> no rvalid, state IDLE, all outputs 0 in the following cycle, and the next req0 is granted normally.
REQ-038 Scenario: req1 only, held for 3 accesses -> consecutive gnt1 with no starvation.
